// File: rtl/split_psum_gen.sv
// Segmented carry-select precompute: per-segment sums/carries for carry-in 0 and 1, SPC segments per RUN cycle.
// Optional synchronous abort port enabled by defining SPLIT_PSUM_FLUSH_EN.
module split_psum_gen #(
  parameter int IO  = 65536,
  parameter int SS  = ((($clog2(IO)) >> 2) == 0) ? (1 << (($clog2(IO)) >> 1))
                                                 : (1 << (($clog2(IO)) >> 2)),
  parameter int SPC = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IO-1:0]                       a,
  input  logic [IO-1:0]                       b,
  input  logic                                cin,
  output logic                                out_valid,
  input  logic                                out_ready,
`ifdef SPLIT_PSUM_FLUSH_EN
  input  logic                                flush,
`endif
  output logic [IO-1:0]                       psum0,
  output logic [IO-1:0]                       psum1,
  output logic [((IO + SS - 1) / SS)-1:0]     cout0,
  output logic [((IO + SS - 1) / SS)-1:0]     cout1,
  output logic                                cin_out
);

  localparam int N_PARTS  = (IO + SS - 1) / SS;
  localparam int R        = (N_PARTS + SPC - 1) / SPC;
  localparam int LW       = IO - (N_PARTS - 1) * SS;
  localparam int PW       = R * SPC * SS;
  localparam int IW       = $clog2(R * SPC + 1);
  localparam int LAST_IDX = (R - 1) * SPC;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] seg_idx;
  logic [IO-1:0] a_q;
  logic [IO-1:0] b_q;
  logic          cin_q;
  logic          flush_i;
  logic          last_run;
  logic [PW-1:0] a_pad;
  logic [PW-1:0] b_pad;
  logic [SS:0]   s0 [SPC];
  logic [SS:0]   s1 [SPC];

`ifdef SPLIT_PSUM_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign last_run  = (seg_idx == IW'(LAST_IDX));
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign cin_out   = cin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      seg_idx <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            cin_q   <= cin;
            seg_idx <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            state   <= IDLE;
            seg_idx <= '0;
          end else if (last_run) begin
            state   <= DONE;
            seg_idx <= '0;
          end else begin
            seg_idx <= seg_idx + IW'(SPC);
          end
        end
        DONE: begin
          if (flush_i || out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-pad so the final, possibly partial, group of slots never reads past the operand.
  generate
    if (PW > IO) begin : g_pad
      assign a_pad = {{(PW - IO){1'b0}}, a_q};
      assign b_pad = {{(PW - IO){1'b0}}, b_q};
    end else begin : g_nopad
      assign a_pad = a_q;
      assign b_pad = b_q;
    end
  endgenerate

  // Slot k adds segment seg_idx+k; only SPC adders exist regardless of IO.
  generate
    for (genvar k = 0; k < SPC; k++) begin : g_slot
      logic [SS-1:0] as;
      logic [SS-1:0] bs;
      assign as    = a_pad[(int'(seg_idx) + k) * SS +: SS];
      assign bs    = b_pad[(int'(seg_idx) + k) * SS +: SS];
      assign s0[k] = {1'b0, as} + {1'b0, bs};
      assign s1[k] = {1'b0, as} + {1'b0, bs} + {{SS{1'b0}}, 1'b1};
    end
  endgenerate

  // seg_idx is always a multiple of SPC, so segment j is always produced by slot j%SPC.
  generate
    for (genvar j = 0; j < N_PARTS; j++) begin : g_seg
      localparam int W = (j == N_PARTS - 1) ? LW : SS;
      localparam int K = j % SPC;
      localparam int C = (j / SPC) * SPC;
      logic [W-1:0] p0_q;
      logic [W-1:0] p1_q;
      logic         c0_q;
      logic         c1_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p0_q <= '0;
          p1_q <= '0;
          c0_q <= 1'b0;
          c1_q <= 1'b0;
        end else if ((state == RUN) && !flush_i && (seg_idx == IW'(C))) begin
          p0_q <= s0[K][W-1:0];
          p1_q <= s1[K][W-1:0];
          c0_q <= s0[K][W];
          c1_q <= s1[K][W];
        end
      end

      assign psum0[j*SS +: W] = p0_q;
      assign psum1[j*SS +: W] = p1_q;
      assign cout0[j]         = c0_q;
      assign cout1[j]         = c1_q;
    end
  endgenerate

endmodule

// File: doc/split_psum_gen.md
# split_psum_gen

Segmented carry-select precompute stage for the modular-multiplier datapath. Takes two IO-bit operands and produces, per SS-bit segment, the candidate sums and carry-outs for segment carry-in 0 and carry-in 1 (psum0/psum1, cout0/cout1). These are the exact inputs the split-adder select stage consumes. Segments are evaluated SPC per cycle so the wide add is spread over multiple cycles, and results are presented through a valid/ready handshake.

## Interface
- IO, default 65536: operand width in bits.
- SS, default 1<<($clog2(IO)>>2), or 1<<($clog2(IO)>>1) when that exponent is 0: segment width in bits.
- SPC, default 1: segments evaluated per RUN cycle, 1..N_PARTS.
- Local N_PARTS = ceil(IO/SS).
- Local R = ceil(N_PARTS/SPC).
- Last segment width is IO-(N_PARTS-1)*SS.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a, b  in  IO  operands.
- cin  in  1  global carry-in, passed through.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- psum0, psum1  out  IO  per-segment sums assuming segment carry-in 0 / 1.
- cout0, cout1  out  N_PARTS  per-segment carry-out assuming carry-in 0 / 1.
- cin_out  out  1  latched cin.

## Operation
- FSM has three states, IDLE, RUN and DONE; reset state is IDLE.
- IDLE
  - in_ready=1.
  - On in_valid, latch a, b and cin; clear seg_idx to 0; go to RUN.
- RUN
  - Each cycle, for segments j = seg_idx .. min(seg_idx+SPC, N_PARTS)-1, with width w_j (SS, or the last-segment width):
    - {cout0[j], psum0 seg j} = a_j + b_j, computed at w_j+1 bits.
    - {cout1[j], psum1 seg j} = a_j + b_j + 1, computed at w_j+1 bits.
  - Then seg_idx += SPC.
  - After R RUN cycles, go to DONE.
  - in_valid is ignored while in RUN.
- DONE
  - out_valid=1. All outputs are held stable until out_ready.
  - On out_ready, go to IDLE.
- Segment j occupies bits [min(j*SS+SS, IO)-1 : j*SS].
- Segment results not yet computed in RUN hold their previous value. Consumers must look only at DONE.
- Invariant: if cout0[j]=1 then cout1[j]=1.

## Timing
- Reset values: in_ready=0 while rst_n is low, and 1 in IDLE after reset; out_valid=0; psum0, psum1, cout0, cout1 and cin_out are all 0; seg_idx=0; state=IDLE.
- Latency: with acceptance at edge T, out_valid is first high after edge T+R. Example: IO=16, SS=4, SPC=1 gives R=4.
- Throughput: one operation per R+2 cycles at most. in_ready is low in DONE, so an out_ready/in_valid overlap accepts the new operands one cycle later, from IDLE.
- Segment results register on the RUN edge that computes them.
- Asynchronous reset during RUN or DONE aborts immediately to the reset values. The operation is discarded.
- out_ready is ignored outside DONE.

## Configuration
- SPLIT_PSUM_FLUSH_EN defined:
  - Adds input port flush (1 bit, synchronous).
  - flush=1 in RUN or DONE returns to IDLE on the next edge, clears out_valid, and leaves the data outputs unchanged.
  - flush takes priority over out_ready.
  - flush in IDLE has no effect and does not block acceptance.
- SPLIT_PSUM_FLUSH_EN not defined: no flush port; behaviour exactly as above.

## Test plan
- IO=16, SS=4, SPC=1, a=0x00FF, b=0x0001, cin=0 -> out_valid after 4 RUN cycles. Required: psum0=0x00F0, psum1=0x1101, cout0=4'b0001, cout1=4'b0011, cin_out=0. A select stage fed these outputs yields 0x0100.
- IO=10, SS=4, SPC=2, a=0x3FF, b=0x001, cin=1 -> R=2. Required: psum0=0x3F0, psum1=0x001, cout0=3'b001, cout1=3'b111, cin_out=1.
- Hold out_ready=0 for 5 cycles in DONE -> all outputs stable and in_ready=0. Then out_ready=1 -> IDLE next cycle, with in_ready=1.
- Pulse in_valid with new operands during RUN -> ignored; results match the first operands only.
- Drive rst_n low for 1 cycle in the middle of RUN -> all outputs 0 and state IDLE. The next operation completes correctly from scratch.
- With SPLIT_PSUM_FLUSH_EN defined, assert flush on the 2nd RUN cycle -> no out_valid; the next accepted operation completes correctly.
